// File: rtl/dcache_wb_direct_if.sv
// Bundle of the core-side request port and the memory-side block port of dcache_wb_direct.
// master is the environment (MEM stage plus memory), slave is the cache.
interface dcache_wb_direct_if;
    // Core side
    logic [31:0]  addr;
    logic         read;
    logic         write;
    logic [31:0]  write_data;
    logic [1:0]   write_size;
    logic         flush;
    logic [31:0]  read_data;
    logic         data_valid;
    logic         flush_done;
    // Memory side
    logic [31:0]  mem_addr;
    logic         blk_read;
    logic [255:0] block_read;
    logic         block_read_valid;
    logic         blk_write;
    logic [255:0] block_write;
    logic         block_write_valid;

    modport master (
        output addr, read, write, write_data, write_size, flush,
        output block_read, block_read_valid, block_write_valid,
        input  read_data, data_valid, flush_done,
        input  mem_addr, blk_read, blk_write, block_write
    );

    modport slave (
        input  addr, read, write, write_data, write_size, flush,
        input  block_read, block_read_valid, block_write_valid,
        output read_data, data_valid, flush_done,
        output mem_addr, blk_read, blk_write, block_write
    );
endinterface

// File: rtl/dcache_wb_direct.sv
// Direct-mapped, write-back, write-allocate data cache with 8-word lines and
// a full write-back-and-invalidate flush.
module dcache_wb_direct #(
    parameter int INDEX_BITS = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    dcache_wb_direct_if.slave bus,
    output logic [2:0]        state_o
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITEBACK  = 3'd1,
        FILL       = 3'd2,
        FLUSH_SCAN = 3'd3,
        FLUSH_WB   = 3'd4,
        FLUSH_DONE = 3'd5
    } state_e;

    state_e                state_q;
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [255:0]          data_q [LINES];
    logic [INDEX_BITS-1:0] line_q;
    logic [31:0]           mem_addr_q;
    logic                  blk_read_q;
    logic                  blk_write_q;
    logic                  flush_done_q;

    logic [1:0]            req_off;
    logic [2:0]            req_word;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req;
    logic                  hit;
    logic                  idle_req;
    logic                  write_hit;
    logic [31:0]           sel_word;
    logic [2:0]            wr_len;
    logic [3:0]            byte_en;
    logic [31:0]           merged;

    assign req_off   = bus.addr[1:0];
    assign req_word  = bus.addr[4:2];
    assign req_idx   = bus.addr[4+INDEX_BITS:5];
    assign req_tag   = bus.addr[31:5+INDEX_BITS];
    assign req       = bus.read | bus.write;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle_req  = (state_q == IDLE) && !bus.flush && req;
    assign write_hit = idle_req && bus.write && hit;
    assign sel_word  = data_q[req_idx][{req_word, 5'b0} +: 32];

    // Big-endian lanes: byte k sits in word bits [31-8k -: 8]; lanes past 3 are dropped.
    always_comb begin
        wr_len  = (bus.write_size == 2'd0) ? 3'd4 : {1'b0, bus.write_size};
        byte_en = '0;
        merged  = sel_word;
        for (int k = 0; k < 4; k++) begin
            byte_en[k] = (3'(k) >= {1'b0, req_off}) && (3'(k) < ({1'b0, req_off} + wr_len));
            if (byte_en[k]) begin
                merged[31-8*k -: 8] = bus.write_data[31-8*k -: 8];
            end
        end
    end

    // A hit completes in the same cycle; an idle port with no request reads as ready.
    assign bus.data_valid  = (state_q == IDLE) && !bus.flush && (!req || hit);
    assign bus.read_data   = idle_req ? sel_word : 32'd0;
    assign bus.flush_done  = flush_done_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.blk_read    = blk_read_q;
    assign bus.blk_write   = blk_write_q;
    assign bus.block_write = data_q[line_q];
    assign state_o         = state_q;

    // Memory handshake: blk_read/blk_write rise on entry to their state, hold mem_addr and
    // block_write stable until the matching *_valid pulse, and drop the cycle after it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            line_q       <= '0;
            mem_addr_q   <= '0;
            blk_read_q   <= 1'b0;
            blk_write_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        state_q <= FLUSH_SCAN;
                        line_q  <= '0;
                    end else if (req && !hit) begin
                        line_q <= req_idx;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_q     <= WRITEBACK;
                            blk_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[req_idx], req_idx, 5'b0};
                        end else begin
                            state_q    <= FILL;
                            blk_read_q <= 1'b1;
                            mem_addr_q <= {bus.addr[31:5], 5'b0};
                        end
                    end else if (write_hit) begin
                        dirty_q[req_idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (bus.block_write_valid) begin
                        state_q         <= FILL;
                        dirty_q[line_q] <= 1'b0;
                        blk_write_q     <= 1'b0;
                        blk_read_q      <= 1'b1;
                        mem_addr_q      <= {bus.addr[31:5], 5'b0};
                    end
                end
                FILL: begin
                    if (bus.block_read_valid) begin
                        state_q         <= IDLE;
                        valid_q[line_q] <= 1'b1;
                        dirty_q[line_q] <= 1'b0;
                        blk_read_q      <= 1'b0;
                    end
                end
                FLUSH_SCAN: begin
                    if (valid_q[line_q] && dirty_q[line_q]) begin
                        state_q     <= FLUSH_WB;
                        blk_write_q <= 1'b1;
                        mem_addr_q  <= {tag_q[line_q], line_q, 5'b0};
                    end else begin
                        valid_q[line_q] <= 1'b0;
                        // The last index ends the scan rather than letting the counter wrap.
                        if (line_q == '1) begin
                            state_q      <= FLUSH_DONE;
                            flush_done_q <= 1'b1;
                        end else begin
                            line_q <= line_q + 1'b1;
                        end
                    end
                end
                FLUSH_WB: begin
                    if (bus.block_write_valid) begin
                        state_q         <= FLUSH_SCAN;
                        dirty_q[line_q] <= 1'b0;
                        blk_write_q     <= 1'b0;
                    end
                end
                FLUSH_DONE: begin
                    if (!bus.flush) begin
                        state_q      <= IDLE;
                        flush_done_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data arrays are not reset; validity alone decides whether a line is usable.
    always_ff @(posedge CLK) begin
        if ((state_q == FILL) && bus.block_read_valid) begin
            tag_q[line_q]  <= bus.addr[31:5+INDEX_BITS];
            data_q[line_q] <= bus.block_read;
        end else if (write_hit) begin
            data_q[req_idx][{req_word, 5'b0} +: 32] <= merged;
        end
    end
endmodule

// File: tb/tb_dcache_wb_direct.sv
// Bench for dcache_wb_direct: directed scenarios followed by random loads, stores and
// flushes, all checked against a flat word-memory reference and a residency model.
module tb_dcache_wb_direct;
    localparam int IB    = 5;
    localparam int LINES = 1 << IB;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic [2:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    dcache_wb_direct_if bus();

    dcache_wb_direct #(.INDEX_BITS(IB)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference state ----------------
    logic [31:0]      bk   [int unsigned];   // backing memory as the responder holds it
    logic [31:0]      gold [int unsigned];   // memory as the core must observe it
    bit               m_valid [LINES];
    bit               m_dirty [LINES];
    logic [26-IB:0]   m_tag   [LINES];
    logic [31:0]      rd_log[$];
    logic [31:0]      wb_addr_log[$];
    logic [255:0]     wb_data_log[$];
    logic [31:0]      exp_q[$];
    logic [255:0]     exp_blk_q[$];
    int               last_rd_cyc = 0;
    int               fixed_lat   = 0;
    logic [26-IB:0]   tsel [4];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] bk_rd(input int unsigned wa);
        if (bk.exists(wa)) return bk[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] gold_rd(input int unsigned wa);
        if (gold.exists(wa)) return gold[wa];
        return init_word(wa);
    endfunction

    function automatic logic [255:0] bk_blk(input logic [26:0] b);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = bk_rd(32'({b, 3'(w)}));
        return r;
    endfunction

    function automatic logic [255:0] gold_blk(input logic [26:0] b);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = gold_rd(32'({b, 3'(w)}));
        return r;
    endfunction

    task automatic model_invalidate();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        bus.block_read        = '0;
        bus.block_read_valid  = 1'b0;
        bus.block_write_valid = 1'b0;
        forever begin
            @(negedge CLK);
            bus.block_read_valid  = 1'b0;
            bus.block_write_valid = 1'b0;
            if (!RESET) begin
                cnt = 0;
            end else if (bus.blk_read || bus.blk_write) begin
                check("req_overlap", 256'(bus.blk_read & bus.blk_write), 256'd0);
                if (cnt == 0) lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    if (bus.blk_write) begin
                        wb_addr_log.push_back(bus.mem_addr);
                        wb_data_log.push_back(bus.block_write);
                        for (int w = 0; w < 8; w++)
                            bk[32'({bus.mem_addr[31:5], 3'(w)})] = bus.block_write[32*w +: 32];
                        bus.block_write_valid = 1'b1;
                    end else begin
                        rd_log.push_back(bus.mem_addr);
                        bus.block_read       = bk_blk(bus.mem_addr[31:5]);
                        last_rd_cyc          = cyc;
                        bus.block_read_valid = 1'b1;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge CLK);
        RESET          = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.flush      = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_blk_read",   256'(bus.blk_read),   256'd0);
        check("rst_blk_write",  256'(bus.blk_write),  256'd0);
        check("rst_flush_done", 256'(bus.flush_done), 256'd0);
        check("rst_mem_addr",   256'(bus.mem_addr),   256'd0);
        check("rst_idle_dv",    256'(bus.data_valid), 256'd1);
        check("rst_idle_rdata", 256'(bus.read_data),  256'd0);
        RESET = 1'b1;
        model_invalidate();
    endtask

    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, output logic [31:0] rdata);
        int           idx;
        int           n;
        int           dv_cyc;
        int           nb;
        bit           done;
        bit           exp_hit;
        bit           exp_wb;
        logic [31:0]  exp_word;
        logic [31:0]  vic_addr;
        logic [255:0] vic_data;
        logic [31:0]  w;
        idx      = int'(a[IB+4:5]);
        exp_hit  = m_valid[idx] && (m_tag[idx] == a[31:IB+5]);
        exp_wb   = !exp_hit && m_valid[idx] && m_dirty[idx];
        vic_addr = {m_tag[idx], IB'(idx), 5'b0};
        vic_data = gold_blk({m_tag[idx], IB'(idx)});
        exp_word = gold_rd(32'(a[31:2]));
        rd_log.delete();
        wb_addr_log.delete();
        wb_data_log.delete();
        @(negedge CLK);
        bus.addr       = a;
        bus.read       = rd;
        bus.write      = wr;
        bus.write_data = wd;
        bus.write_size = sz;
        n      = 0;
        done   = 1'b0;
        dv_cyc = 0;
        rdata  = '0;
        while (!done && n < 200) begin
            #1;
            if (n == 0) check("first_cycle_dv", 256'(bus.data_valid), 256'(exp_hit));
            if (bus.data_valid) begin
                done   = 1'b1;
                rdata  = bus.read_data;
                dv_cyc = cyc;
            end else begin
                @(negedge CLK);
                n++;
            end
        end
        check("access_done", 256'(done), 256'd1);
        @(negedge CLK);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        #1;
        check("idle_dv",    256'(bus.data_valid), 256'd1);
        check("idle_rdata", 256'(bus.read_data),  256'd0);
        if (rd && !wr) check("read_data", 256'(rdata), 256'(exp_word));
        if (exp_hit) begin
            check("hit_no_traffic", 256'(rd_log.size() + wb_addr_log.size()), 256'd0);
        end else begin
            check("wb_count", 256'(wb_addr_log.size()), 256'(exp_wb));
            if (exp_wb && wb_addr_log.size() > 0) begin
                check("wb_addr", 256'(wb_addr_log[0]), 256'(vic_addr));
                check("wb_data", wb_data_log[0], vic_data);
            end
            check("fill_count", 256'(rd_log.size()), 256'd1);
            if (rd_log.size() > 0) check("fill_addr", 256'(rd_log[0]), 256'({a[31:5], 5'b0}));
            check("miss_latency", 256'(dv_cyc), 256'(last_rd_cyc + 1));
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = a[31:IB+5];
        end
        if (wr) begin
            m_dirty[idx] = 1'b1;
            w  = gold_rd(32'(a[31:2]));
            nb = (sz == 2'd0) ? 4 : int'(sz);
            for (int k = 0; k < 4; k++)
                if (k >= int'(a[1:0]) && k < int'(a[1:0]) + nb) w[31-8*k -: 8] = wd[31-8*k -: 8];
            gold[32'(a[31:2])] = w;
        end
    endtask

    task automatic do_flush();
        int n;
        int hold;
        exp_q.delete();
        exp_blk_q.delete();
        for (int i = 0; i < LINES; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                exp_q.push_back({m_tag[i], IB'(i), 5'b0});
                exp_blk_q.push_back(gold_blk({m_tag[i], IB'(i)}));
            end
        end
        rd_log.delete();
        wb_addr_log.delete();
        wb_data_log.delete();
        @(negedge CLK);
        bus.flush = 1'b1;
        bus.read  = ($urandom_range(0, 1) == 1);
        n = 0;
        #1;
        check("flush_dv", 256'(bus.data_valid), 256'd0);
        while (!bus.flush_done && n < 3000) begin
            @(negedge CLK);
            #1;
            n++;
            if (!bus.flush_done) check("flush_dv", 256'(bus.data_valid), 256'd0);
        end
        check("flush_done_seen", 256'(bus.flush_done), 256'd1);
        if (exp_q.size() == 0) check("flush_clean_latency", 256'(n), 256'(LINES + 1));
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge CLK);
            #1;
            check("flush_done_held", 256'(bus.flush_done), 256'd1);
        end
        bus.flush = 1'b0;
        bus.read  = 1'b0;
        @(negedge CLK);
        #1;
        check("flush_done_drop", 256'(bus.flush_done), 256'd0);
        check("flush_idle_dv",   256'(bus.data_valid), 256'd1);
        check("flush_wb_count",  256'(wb_addr_log.size()), 256'(exp_q.size()));
        check("flush_no_fill",   256'(rd_log.size()), 256'd0);
        for (int j = 0; j < exp_q.size() && j < wb_addr_log.size(); j++) begin
            check("flush_wb_addr", 256'(wb_addr_log[j]), 256'(exp_q[j]));
            check("flush_wb_data", wb_data_log[j], exp_blk_q[j]);
        end
        model_invalidate();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          n;
        int          op;
        bus.addr       = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.write_data = '0;
        bus.write_size = '0;
        bus.flush      = 1'b0;
        tsel[0] = '0;
        tsel[1] = 22'h1;
        tsel[2] = 22'h2;
        tsel[3] = 22'h2AAAA;
        bk[32'h48 >> 2]   = 32'hDEADBEEF;
        gold[32'h48 >> 2] = 32'hDEADBEEF;
        apply_reset();

        // Clean miss, then hit on the filled line, then a one-byte store.
        access(1'b0, 1'b1, 32'h40, 32'h0, 2'd0, r);
        access(1'b0, 1'b1, 32'h48, 32'h0, 2'd0, r);
        check("tp_hit_word", 256'(r), 256'(32'hDEADBEEF));
        access(1'b1, 1'b0, 32'h49, 32'h00AA0000, 2'd1, r);
        access(1'b0, 1'b1, 32'h48, 32'h0, 2'd0, r);
        check("tp_merged_word", 256'(r), 256'(32'hDEAABEEF));

        // Conflict on the same index evicts the dirty line first.
        access(1'b0, 1'b1, 32'h440, 32'h0, 2'd0, r);
        check("tp_evict_addr", 256'(wb_addr_log[0]), 256'(32'h40));
        check("tp_evict_word", 256'(wb_data_log[0][95:64]), 256'(32'hDEAABEEF));
        check("tp_refill_addr", 256'(rd_log[0]), 256'(32'h440));

        // Full-word store, then flush writes back exactly that block.
        access(1'b1, 1'b0, 32'h100, 32'h12345678, 2'd0, r);
        do_flush();
        check("tp_flush_one_wb", 256'(wb_addr_log.size()), 256'd1);
        check("tp_flush_wb_addr", 256'(wb_addr_log[0]), 256'(32'h100));
        access(1'b0, 1'b1, 32'h100, 32'h0, 2'd0, r);
        check("tp_after_flush_miss", 256'(rd_log.size()), 256'd1);
        check("tp_after_flush_word", 256'(r), 256'(32'h12345678));
        do_flush();

        // Reset in the middle of a fill abandons it.
        fixed_lat = 40;
        @(negedge CLK);
        bus.addr = 32'h200;
        bus.read = 1'b1;
        n = 0;
        #1;
        while (!bus.blk_read && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("rst_fill_started", 256'(bus.blk_read), 256'd1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_fill_blk_read_drop", 256'(bus.blk_read), 256'd0);
        check("rst_fill_mem_addr", 256'(bus.mem_addr), 256'd0);
        bus.read = 1'b0;
        @(negedge CLK);
        RESET     = 1'b1;
        fixed_lat = 0;
        model_invalidate();
        access(1'b0, 1'b1, 32'h200, 32'h0, 2'd0, r);
        check("rst_fill_remiss", 256'(rd_log.size()), 256'd1);

        // Random mix over a few tags and indices to force conflicts and write-backs.
        for (int i = 0; i < 300; i++) begin
            a  = {tsel[$urandom_range(0, 3)], IB'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 19);
            if (op == 0)       do_flush();
            else if (op < 10)  access(1'b0, 1'b1, a, 32'h0, 2'd0, r);
            else if (op < 18)  access(1'b1, 1'b0, a, $urandom, 2'($urandom_range(0, 3)), r);
            else               access(1'b1, 1'b1, a, $urandom, 2'($urandom_range(0, 3)), r);
        end
        do_flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
